debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised N-channel push-button conditioner: synchroniser, debounce, edge detection and long-press detection per channel.
- Sits between raw board buttons/switches and the game/control FSMs.
- Those FSMs consume one-cycle PRESS/RELEASE/LONG pulses instead of raw levels.
- Successor to the single-channel fixed-count debounce: adds channel count, configurable window, polarity, release edge, hold detection and optional auto-repeat.

Parameters:
- N_CH, 4, number of independent channels.
- DB_CYCLES, 16, consecutive agreeing samples needed to change debounced state (legal range 2..65535).
- HOLD_CYCLES, 1000, cycles of stable press before LONG fires (at least 1).
- REPEAT_CYCLES, 200, auto-repeat period after LONG (at least 1; used only with the optional feature).
- ACTIVE_LOW, 1, 1 = raw input low means pressed; applies to all channels.

Ports:
- DEBOUNCE_CLK  input  1  single clock, all logic rising-edge.
- RESET  input  1  synchronous, active-high reset.
- RAW  input  N_CH  asynchronous raw button levels.
- STABLE  output  N_CH  debounced level, 1 = pressed.
- PRESS_PULSE  output  N_CH  one-cycle pulse on debounced press.
- RELEASE_PULSE  output  N_CH  one-cycle pulse on debounced release.
- LONG_PULSE  output  N_CH  one-cycle pulse when a press reaches HOLD_CYCLES.
- LONG_HELD  output  N_CH  level, 1 from LONG_PULSE until release.

Behaviour:
- Per channel, fully independent. Channel i uses bit i of every port.
- Polarity: in = RAW[i] XOR ACTIVE_LOW, applied before synchronisation.
- Sync: two flops, sync1 <= in, s <= sync1.
- Reset: RESET=1 at a clock edge clears sync flops, STABLE, all pulses, LONG_HELD, DB count and HOLD count. This holds mid-operation too; no pulse is emitted on reset.
- Debounce counter: width clog2(DB_CYCLES). Each edge:
  - s == STABLE: count <= 0.
  - s != STABLE and count == DB_CYCLES-1: STABLE <= s, count <= 0, PRESS_PULSE <= s, RELEASE_PULSE <= ~s.
  - otherwise: count <= count+1.
- Any agreeing sample restarts the window; bounces shorter than DB_CYCLES are fully rejected.
- Latency: a raw change sampled at edge k appears on STABLE after edge k+1+DB_CYCLES, i.e. DB_CYCLES+2 cycles including sync.
- PRESS_PULSE/RELEASE_PULSE:
  - Registered; high for exactly the first cycle STABLE shows its new value, low otherwise.
  - Never both high. At least DB_CYCLES cycles separate consecutive edges on one channel.
- Hold counter: width clog2(HOLD_CYCLES+1).
  - Clears while STABLE=0.
  - While STABLE=1, increments saturating at HOLD_CYCLES.
  - The cycle it steps to HOLD_CYCLES: LONG_PULSE=1 for one cycle and LONG_HELD <= 1.
  - Timing: LONG_PULSE is asserted HOLD_CYCLES cycles after PRESS_PULSE.
  - LONG_HELD clears in the same cycle as RELEASE_PULSE.
  - Release before saturation gives no LONG_PULSE. Saturation prevents re-fire and wrap.
- Simultaneous events across channels are all reported in the same cycle; no arbitration.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Per-channel repeat counter starts at 0 on LONG_PULSE.
  - While LONG_HELD=1, PRESS_PULSE re-fires one cycle every REPEAT_CYCLES cycles. First repeat comes REPEAT_CYCLES after LONG_PULSE.
  - Counter clears on release or reset.
- Undefined: no repeat counter is synthesised. PRESS_PULSE fires once per press. REPEAT_CYCLES is ignored.

Decomposition:
- Package debounce_pkg holds:
  - clog2-based width helper function.
  - Default constants DB_CYCLES_DEF, HOLD_CYCLES_DEF, REPEAT_CYCLES_DEF.
- Sub-module debounce_channel: one channel (sync, DB counter, hold counter, optional repeat).
- Top debounce_multi instantiates N_CH copies with a generate loop and packs the bits.

Test Plan:
- Reset with RAW=all 1 (ACTIVE_LOW=1), DB_CYCLES=4 -> all outputs 0 from first post-reset cycle; no pulses.
- Ch0 RAW 1->0 clean at edge k -> STABLE[0] rises after edge k+5; PRESS_PULSE[0] high exactly that cycle; other channels unchanged.
- Ch1 bounce 0/1 alternating every 2 cycles for 30 cycles, then steady 0 -> no pulse during bounce; exactly one PRESS_PULSE[1] 6 cycles after steady.
- HOLD_CYCLES=10, press held 20 cycles -> LONG_PULSE 10 cycles after PRESS_PULSE; LONG_HELD high until release; exactly one LONG_PULSE.
  - Held only 8 cycles -> no LONG_PULSE.
  - Release -> RELEASE_PULSE and LONG_HELD=0 in the same cycle.
- RESET asserted mid-window (count=2) and mid-hold -> counters cleared; no pulse; after deassert a still-pressed button needs a full DB_CYCLES+2 to re-assert.
- DEBOUNCE_AUTOREPEAT_EN, HOLD_CYCLES=10, REPEAT_CYCLES=5, hold 31 cycles past PRESS -> PRESS_PULSE at +0, +15, +20, +25, +30; none after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and the counter-width helper for the
// push-button conditioner (debounce_channel, debounce_multi).
package debounce_pkg;

  localparam int DB_CYCLES_DEF     = 16;
  localparam int HOLD_CYCLES_DEF   = 1000;
  localparam int REPEAT_CYCLES_DEF = 200;

  // Bits needed for a counter holding 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel -- polarity fix, 2-flop synchroniser,
// debounce window, press/release edge pulses, long-press detection and
// (with DEBOUNCE_AUTOREPEAT_EN defined) PRESS auto-repeat while held long.
// Ports:
//   DEBOUNCE_CLK  clock, rising edge
//   RESET         synchronous, active-high
//   raw           asynchronous raw button level
//   stable        debounced level, 1 = pressed
//   press_pulse   one-cycle pulse on debounced press (and on each repeat)
//   release_pulse one-cycle pulse on debounced release
//   long_pulse    one-cycle pulse when a press has lasted HOLD_CYCLES
//   long_held     1 from long_pulse until release
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic DEBOUNCE_CLK,
  input  logic RESET,
  input  logic raw,
  output logic stable,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);

  localparam int DBW = cnt_width(DB_CYCLES);
  localparam int HW  = cnt_width(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic           sync1, s;
  logic [DBW-1:0] db_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           commit, rel_commit, long_fire;

  // commit: this edge the window completes and the debounced level flips.
  assign commit     = (s != stable) && (db_cnt == DB_LAST);
  assign rel_commit = commit && stable;
  // Long fires on the step to HOLD_CYCLES, unless the release lands on the
  // same edge (a press that ends exactly at saturation is not a long press).
  assign long_fire  = stable && !rel_commit && (hold_cnt == HOLD_LAST);

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt;
`endif

  always_ff @(posedge DEBOUNCE_CLK) begin
    if (RESET) begin
      sync1         <= 1'b0;
      s             <= 1'b0;
      stable        <= 1'b0;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      long_held     <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      sync1         <= raw ^ POL;
      s             <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= long_fire;

      // Any agreeing sample restarts the window.
      if (s == stable) begin
        db_cnt <= '0;
      end else if (commit) begin
        stable        <= s;
        db_cnt        <= '0;
        press_pulse   <= s;
        release_pulse <= ~s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // Hold counter saturates so long_pulse cannot re-fire or wrap.
      if (!stable || rel_commit) begin
        hold_cnt  <= '0;
        long_held <= 1'b0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (long_fire) long_held <= 1'b1;
      end

`ifdef DEBOUNCE_AUTOREPEAT_EN
      // Repeat phase restarts at long_pulse; first repeat REPEAT_CYCLES later.
      // stable is 1 whenever this fires, so it never collides with a
      // debounce-driven press_pulse.
      if (!stable || rel_commit || long_fire) begin
        rep_cnt <= '0;
      end else if (long_held) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt     <= '0;
          press_pulse <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent push-button conditioners. Channel i uses
// bit i of every port.
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to make PRESS_PULSE repeat
// every REPEAT_CYCLES while LONG_HELD is set; otherwise REPEAT_CYCLES is unused.
// Ports:
//   DEBOUNCE_CLK   clock, rising edge
//   RESET          synchronous, active-high
//   RAW            [N_CH] asynchronous raw button levels
//   STABLE         [N_CH] debounced level, 1 = pressed
//   PRESS_PULSE    [N_CH] one-cycle pulse on debounced press
//   RELEASE_PULSE  [N_CH] one-cycle pulse on debounced release
//   LONG_PULSE     [N_CH] one-cycle pulse when a press reaches HOLD_CYCLES
//   LONG_HELD      [N_CH] level, 1 from LONG_PULSE until release
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic            DEBOUNCE_CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] RAW,
  output logic [N_CH-1:0] STABLE,
  output logic [N_CH-1:0] PRESS_PULSE,
  output logic [N_CH-1:0] RELEASE_PULSE,
  output logic [N_CH-1:0] LONG_PULSE,
  output logic [N_CH-1:0] LONG_HELD
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .DEBOUNCE_CLK (DEBOUNCE_CLK),
      .RESET        (RESET),
      .raw          (RAW[i]),
      .stable       (STABLE[i]),
      .press_pulse  (PRESS_PULSE[i]),
      .release_pulse(RELEASE_PULSE[i]),
      .long_pulse   (LONG_PULSE[i]),
      .long_held    (LONG_HELD[i])
    );
  end

endmodule
